// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared port indices and default widths for the writeback arbiter
package rf_wb_arbiter_pkg;
    localparam int PORT_ALU = 0;
    localparam int PORT_LSU = 1;
    localparam int RF_ADDR_LEN_DEF = 5;
    localparam int RF_DATA_LEN_DEF = 32;
endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter2: two-input round-robin grant, favouring the port not granted last
module rr_arbiter2
    import rf_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic last_grant_q;
    logic last_grant_d;

    // Grant a lone requester outright; on conflict pick the port not granted last
    always_comb begin
        grant = rst ? 2'b00 : (&valid) ? (last_grant_q ? 2'b01 : 2'b10) : valid;
        last_grant_d = grant[PORT_LSU] ? 1'b1 : grant[PORT_ALU] ? 1'b0 : last_grant_q;
    end

    // Reset to port 1 so port 0 wins the first conflict
    always_ff @(posedge clk) begin
        if (rst) last_grant_q <= 1'b1;
        else     last_grant_q <= last_grant_d;
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: arbitrates ALU/LSU writebacks into one register-file write port and tracks pending writes
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int RF_ADDR_LEN = RF_ADDR_LEN_DEF,
    parameter int RF_DATA_LEN = RF_DATA_LEN_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rsv_valid,
    input  logic [RF_ADDR_LEN-1:0]    rsv_addr,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [RF_ADDR_LEN-1:0]    req0_addr,
    input  logic [RF_DATA_LEN-1:0]    req0_data,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [RF_ADDR_LEN-1:0]    req1_addr,
    input  logic [RF_DATA_LEN-1:0]    req1_data,
    output logic                      rf_w_en,
    output logic [RF_ADDR_LEN-1:0]    rf_rd_addr,
    output logic [RF_DATA_LEN-1:0]    rf_rd_data,
    output logic [2**RF_ADDR_LEN-1:0] pending
);
    localparam int NREG = 2**RF_ADDR_LEN;

    logic [1:0]             grant;
    logic                   xfer;
    logic                   wr;
    logic [RF_ADDR_LEN-1:0] xfer_addr;
    logic [RF_DATA_LEN-1:0] xfer_data;
    logic [NREG-1:0]        set_mask;
    logic [NREG-1:0]        clr_mask;
    logic [NREG-1:0]        pending_q, pending_d;
    logic                   rf_w_en_q, rf_w_en_d;
    logic [RF_ADDR_LEN-1:0] rf_rd_addr_q, rf_rd_addr_d;
    logic [RF_DATA_LEN-1:0] rf_rd_data_q, rf_rd_data_d;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[PORT_ALU];
    assign req1_ready = grant[PORT_LSU];
    assign rf_w_en    = rf_w_en_q;
    assign rf_rd_addr = rf_rd_addr_q;
    assign rf_rd_data = rf_rd_data_q;
    assign pending    = pending_q;

    // Select the granted payload, update the pending bitmap (set wins) and stage the write
    always_comb begin
        xfer = |grant;
        xfer_addr = grant[PORT_LSU] ? req1_addr : req0_addr;
        xfer_data = grant[PORT_LSU] ? req1_data : req0_data;
        wr = xfer && (xfer_addr != '0);
        set_mask = '0;
        clr_mask = '0;
        if (rsv_valid && (rsv_addr != '0)) set_mask[rsv_addr] = 1'b1;
        if (wr) clr_mask[xfer_addr] = 1'b1;
        pending_d = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
        rf_w_en_d = wr;
        rf_rd_addr_d = wr ? xfer_addr : rf_rd_addr_q;
        rf_rd_data_d = wr ? xfer_data : rf_rd_data_q;
    end

    // Output register stage and pending bitmap
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            rf_w_en_q    <= 1'b0;
            rf_rd_addr_q <= '0;
            rf_rd_data_q <= '0;
        end else begin
            pending_q    <= pending_d;
            rf_w_en_q    <= rf_w_en_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            rf_rd_data_q <= rf_rd_data_d;
        end
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameters SHALL be: RF_ADDR_LEN, default 5, register address width; RF_DATA_LEN, default 32, register data width.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rsv_valid  input  1  issue stage reserves a destination register this cycle.
REQ-005 rsv_addr  input  RF_ADDR_LEN  reserved destination index.
REQ-006 req0_valid / req0_ready  input / output  1  ALU writeback handshake.
REQ-007 req0_addr / req0_data  input  RF_ADDR_LEN / RF_DATA_LEN  ALU destination and result.
REQ-008 req1_valid / req1_ready  input / output  1  load-unit writeback handshake.
REQ-009 req1_addr / req1_data  input  RF_ADDR_LEN / RF_DATA_LEN  load destination and data.
REQ-010 rf_w_en  output  1  register-file write enable.
REQ-011 rf_rd_addr / rf_rd_data  output  RF_ADDR_LEN / RF_DATA_LEN  register-file write address and data.
REQ-012 pending  output  2**RF_ADDR_LEN  bit i set = register i has an outstanding write.

Function
REQ-013 Transfer on port N SHALL occur in any cycle where reqN_valid and reqN_ready are both high.
REQ-014 At most one port SHALL be granted per cycle; reqN_ready SHALL be combinational and high only for the granted port.
REQ-015 Single valid requester SHALL be granted that cycle, regardless of arbitration state.
REQ-016 Both valid: grant SHALL go to the port not recorded in last_grant (round-robin).
REQ-017 last_grant SHALL update to the granted port index on every transfer and hold otherwise.
REQ-018 Requester SHALL hold valid, addr, and data stable until ready; the arbiter SHALL NOT drop a stalled request.
REQ-019 Accepted transfer with addr != 0 SHALL drive rf_w_en=1, rf_rd_addr=addr, rf_rd_data=data in the following cycle (latency 1, registered outputs).
REQ-020 Accepted transfer with addr == 0 SHALL complete the handshake but leave rf_w_en=0 the following cycle.
REQ-021 No transfer: rf_w_en SHALL be 0 the following cycle; rf_rd_addr and rf_rd_data SHALL hold their previous values.
REQ-022 rsv_valid with rsv_addr != 0 SHALL set pending[rsv_addr] at the next edge; rsv_addr == 0 SHALL be ignored.
REQ-023 Transfer with addr != 0 SHALL clear pending[addr] at the same edge the write is registered.
REQ-024 Set and clear of the same index in one cycle: set SHALL win, so the bit stays 1 for the newer reservation.
REQ-025 Set and clear of different indices in one cycle SHALL both take effect.
REQ-026 pending[0] SHALL be constant 0.
REQ-027 Writeback to a register with pending=0 SHALL still be written; pending stays 0.
REQ-028 Throughput SHALL be one write per cycle sustained.

Reset
REQ-029 While rst is high: rf_w_en=0, rf_rd_addr=0, rf_rd_data=0, pending=0, last_grant=1 (port 0 wins first conflict).
REQ-030 While rst is high: req0_ready=0 and req1_ready=0; no transfer and no reservation SHALL be recorded.
REQ-031 A request in flight at reset SHALL be discarded; the requester re-presents it after reset.

Structure
REQ-032 Shared package SHALL hold port-index constants (PORT_ALU=0, PORT_LSU=1) and default RF_ADDR_LEN/RF_DATA_LEN.
REQ-033 Two-input round-robin grant logic SHALL be a sub-module rr_arbiter2 (valid[1:0] in, grant[1:0] out, last_grant state inside).
REQ-034 The pending bitmap and output register stage SHALL reside in rf_wb_arbiter.

Verification
REQ-035 req0 only (addr=5, data=0xDEADBEEF) -> req0_ready=1 same cycle; next cycle rf_w_en=1, rf_rd_addr=5, rf_rd_data=0xDEADBEEF.
REQ-036 After reset, both valid (addr 3, 4) held 2 cycles -> port 0 granted cycle 1, port 1 cycle 2; writes to 3 then 4 on consecutive cycles.
REQ-037 rsv 7, then req1 addr=7 -> pending[7] 0->1->0; same-cycle rsv 7 with a req0 addr=7 transfer -> pending[7] stays 1.
REQ-038 req0 addr=0, data=0x1234 -> ready=1, rf_w_en=0 next cycle; rsv_addr=0 -> pending stays 0.
REQ-039 rst asserted while both ports valid and pending=0x000000F0 -> readys 0, rf_w_en=0, pending=0; after release first conflict grants port 0.
REQ-040 Both ports valid continuously for 10 cycles -> grants alternate 0,1,0,1...; exactly 10 rf_w_en pulses, no stalled request lost.
